// File: rtl/i2s_tx_if.sv
// Bus-side bundle for i2s_tx: FIFO write port, status, configuration and serial pins.
// With I2S_TX_UNDERFLOW_EN defined, also carries the sticky underflow flag and its clear.
interface i2s_tx_if #(
  parameter int FIFO_AW = 4
);
  logic              fifo_wr;
  logic [31:0]       fifo_wdata;
  logic [FIFO_AW:0]  fifo_level_threshold;
  logic              fifo_full;
  logic              fifo_empty;
  logic [FIFO_AW:0]  fifo_level;
  logic              fifo_level_below;
  logic [4:0]        sample_size;
  logic [7:0]        sck_prescaler;
  logic [1:0]        channels;
  logic              en;
  logic              sdo;
  logic              ws;
  logic              sck;
`ifdef I2S_TX_UNDERFLOW_EN
  logic              underflow;
  logic              underflow_clr;

  modport master (
    output fifo_wr, fifo_wdata, fifo_level_threshold, sample_size, sck_prescaler,
           channels, en, underflow_clr,
    input  fifo_full, fifo_empty, fifo_level, fifo_level_below, sdo, ws, sck, underflow
  );

  modport slave (
    input  fifo_wr, fifo_wdata, fifo_level_threshold, sample_size, sck_prescaler,
           channels, en, underflow_clr,
    output fifo_full, fifo_empty, fifo_level, fifo_level_below, sdo, ws, sck, underflow
  );
`else
  modport master (
    output fifo_wr, fifo_wdata, fifo_level_threshold, sample_size, sck_prescaler,
           channels, en,
    input  fifo_full, fifo_empty, fifo_level, fifo_level_below, sdo, ws, sck
  );

  modport slave (
    input  fifo_wr, fifo_wdata, fifo_level_threshold, sample_size, sck_prescaler,
           channels, en,
    output fifo_full, fifo_empty, fifo_level, fifo_level_below, sdo, ws, sck
  );
`endif
endinterface

// File: rtl/i2s_tx.sv
// I2S master transmitter: sample FIFO, sck/ws generation, MSB-first Philips-timed sdo.
// Optional macro I2S_TX_UNDERFLOW_EN adds a sticky underflow flag with clear.
module i2s_tx #(
  parameter int FIFO_AW = 4
) (
  input  logic    clk,
  input  logic    rst_n,
  i2s_tx_if.slave bus
);
  // state | meaning
  // IDLE  | en low: sck/ws/sdo held 0, counters cleared, FIFO still accepts writes
  // RUN   | generating sck/ws and shifting the current slot out on sdo
  typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;

  localparam int DEPTH = 2 ** FIFO_AW;

  state_t             state_q;
  logic [7:0]         presc_q;
  logic               sck_q;
  logic               ws_q;
  logic               sdo_q;
  logic [4:0]         bit_cnt_q;
  logic [31:0]        shreg_q;

  logic [31:0]        mem_q [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_q;
  logic [FIFO_AW-1:0] rd_ptr_q;
  logic [FIFO_AW:0]   level_q;
  logic [FIFO_AW:0]   level_d;
  logic               full_q;
  logic               empty_q;

  logic               presc_tc;
  logic               bit_edge;
  logic               wrap;
  logic               load;
  logic               load_right;
  logic               slot_active;
  logic               pop;
  logic               wr_en;
  logic [31:0]        head;
  logic [31:0]        load_word;

  // A load happens on RUN entry (left slot) and on every bit_cnt wrap (slot change).
  always_comb begin
    presc_tc    = (presc_q == 8'd0);
    bit_edge    = (state_q == ST_RUN) && bus.en && presc_tc && sck_q;
    wrap        = bit_edge && (bit_cnt_q == 5'd31);
    load        = ((state_q == ST_IDLE) && bus.en) || wrap;
    load_right  = wrap && !ws_q;
    slot_active = load_right ? bus.channels[1] : bus.channels[0];
    pop         = load && slot_active && !empty_q;
    head        = mem_q[rd_ptr_q];
    load_word   = '0;
    if (pop && (bus.sample_size != 5'd0))
      load_word = head << (6'd32 - {1'b0, bus.sample_size});
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      presc_q   <= 8'd0;
      sck_q     <= 1'b0;
      ws_q      <= 1'b0;
      sdo_q     <= 1'b0;
      bit_cnt_q <= 5'd0;
      shreg_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          sck_q     <= 1'b0;
          ws_q      <= 1'b0;
          sdo_q     <= 1'b0;
          bit_cnt_q <= 5'd0;
          presc_q   <= 8'd0;
          if (bus.en) begin
            state_q <= ST_RUN;
            presc_q <= bus.sck_prescaler;
            shreg_q <= load_word;
          end
        end
        ST_RUN: begin
          if (!bus.en) begin
            state_q   <= ST_IDLE;
            sck_q     <= 1'b0;
            ws_q      <= 1'b0;
            sdo_q     <= 1'b0;
            bit_cnt_q <= 5'd0;
            presc_q   <= 8'd0;
            shreg_q   <= '0;
          end else if (presc_tc) begin
            presc_q <= bus.sck_prescaler;
            sck_q   <= ~sck_q;
            if (bit_edge) begin
              bit_cnt_q <= bit_cnt_q + 5'd1;
              if (wrap) begin
                ws_q    <= ~ws_q;
                sdo_q   <= 1'b0;
                shreg_q <= load_word;
              end else begin
                sdo_q   <= shreg_q[31];
                shreg_q <= {shreg_q[30:0], 1'b0};
              end
            end
          end else begin
            presc_q <= presc_q - 8'd1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    wr_en   = bus.fifo_wr && !full_q;
    level_d = level_q;
    case ({wr_en, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_en)
      mem_q[wr_ptr_q] <= bus.fifo_wdata;
  end

  // level never exceeds DEPTH, so its MSB alone marks full.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      if (wr_en)
        wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)
        rd_ptr_q <= rd_ptr_q + 1'b1;
      level_q <= level_d;
      full_q  <= level_d[FIFO_AW];
      empty_q <= (level_d == '0);
    end
  end

`ifdef I2S_TX_UNDERFLOW_EN
  logic underflow_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      underflow_q <= 1'b0;
    else if (load && slot_active && empty_q)
      underflow_q <= 1'b1;
    else if (bus.underflow_clr)
      underflow_q <= 1'b0;
  end

  assign bus.underflow = underflow_q;
`endif

  assign bus.sck              = sck_q;
  assign bus.ws               = ws_q;
  assign bus.sdo              = sdo_q;
  assign bus.fifo_level       = level_q;
  assign bus.fifo_full        = full_q;
  assign bus.fifo_empty       = empty_q;
  assign bus.fifo_level_below = (level_q < bus.fifo_level_threshold);
endmodule

// File: tb/tb_i2s_tx.sv
// Self-checking bench for i2s_tx: slot scoreboard fed at write time, drained by an sck monitor,
// plus a table of FIFO fill vectors and hand sequences for enable/reset corner cases.
module tb_i2s_tx;
  localparam int AW = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  i2s_tx_if #(.FIFO_AW(AW)) ifc ();
  i2s_tx #(.FIFO_AW(AW)) dut (.clk(clk), .rst_n(rst_n), .bus(ifc));

  typedef struct packed {
    logic        ws;
    logic [31:0] bits;
  } slot_t;

  typedef struct {
    logic [31:0] wdata;
    logic [AW:0] lvl;
    logic        full;
    logic        empty;
    logic        below;
  } vec_t;

  int          checks = 0;
  int          failures = 0;
  slot_t       exp_q[$];
  slot_t       mon_e;
  logic        mon_on = 1'b0;
  int          fall_cnt = 0;
  logic [31:0] col = '0;
  int          col_n = 0;
  logic        col_ws = 1'b0;
  logic        col_ws_bad = 1'b0;
  logic        sck_prev = 1'b0;
  vec_t        vecs[17];
  int          n;
  int          base;
  logic [31:0] w12;
  logic [31:0] w13;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Slot as seen on the wire: bit 0 is zero, bits 1..ss carry the sample MSB first.
  function automatic logic [31:0] slot_pat(input logic [31:0] w, input int ss);
    logic [31:0] r;
    r = '0;
    for (int k = 1; k <= ss; k++) r[31-k] = w[ss-k];
    return r;
  endfunction

  // Collect sdo on each sck rise; every 32 rises form one slot to compare.
  always @(posedge clk) begin
    #1;
    if (!rst_n || !mon_on || !ifc.en) begin
      col_n      = 0;
      col_ws_bad = 1'b0;
    end else begin
      if (sck_prev && !ifc.sck) fall_cnt++;
      if (!sck_prev && ifc.sck) begin
        if (col_n == 0) begin
          col_ws     = ifc.ws;
          col_ws_bad = 1'b0;
        end else if (ifc.ws !== col_ws) begin
          col_ws_bad = 1'b1;
        end
        col = {col[30:0], ifc.sdo};
        col_n++;
        if (col_n == 32) begin
          col_n = 0;
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL slot_unexpected: actual=%0h ws=%0b required=no slot", col, col_ws);
          end else begin
            mon_e = exp_q.pop_front();
            check("slot_bits", col, mon_e.bits);
            check("slot_ws", {col_ws_bad, col_ws}, {1'b0, mon_e.ws});
          end
        end
      end
    end
    sck_prev = ifc.sck;
  end

  task automatic write_word(input logic [31:0] w);
    @(negedge clk);
    ifc.fifo_wr    = 1'b1;
    ifc.fifo_wdata = w;
    @(negedge clk);
    ifc.fifo_wr    = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    check(name, exp_q.size(), 0);
  endtask

  task automatic wait_level(input string name, input logic [AW:0] lv, input int budget);
    int k;
    k = 0;
    @(negedge clk);
    while (ifc.fifo_level !== lv && k < budget) begin
      @(negedge clk);
      k++;
    end
    check(name, ifc.fifo_level, lv);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    ifc.fifo_wr              = 1'b0;
    ifc.fifo_wdata           = '0;
    ifc.fifo_level_threshold = 5'd5;
    ifc.sample_size          = 5'd18;
    ifc.sck_prescaler        = 8'd4;
    ifc.channels             = 2'b11;
    ifc.en                   = 1'b0;
`ifdef I2S_TX_UNDERFLOW_EN
    ifc.underflow_clr        = 1'b0;
`endif

    // Reset values (100 clk = 1000 ns)
    repeat (100) @(posedge clk);
    #1;
    check("rst_sck", ifc.sck, 0);
    check("rst_ws", ifc.ws, 0);
    check("rst_sdo", ifc.sdo, 0);
    check("rst_level", ifc.fifo_level, 0);
    check("rst_empty", ifc.fifo_empty, 1);
    check("rst_full", ifc.fifo_full, 0);
    check("rst_below_thr5", ifc.fifo_level_below, 1);
    ifc.fifo_level_threshold = 5'd0;
    #1;
    check("rst_below_thr0", ifc.fifo_level_below, 0);
    ifc.fifo_level_threshold = 5'd5;
`ifdef I2S_TX_UNDERFLOW_EN
    check("rst_underflow", ifc.underflow, 0);
`endif
    @(negedge clk);
    rst_n  = 1'b1;
    mon_on = 1'b1;

    // Stereo, 18-bit samples, p=4
    write_word(32'h0002_ABCD);
    write_word(32'h0001_5432);
    exp_q.push_back('{ws: 1'b0, bits: 32'h5579_A000});
    exp_q.push_back('{ws: 1'b1, bits: 32'h2A86_4000});
    ifc.en = 1'b1;
    @(posedge clk);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!ifc.sck && n < 50);
    check("first_rise_clks", n, 5);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (ifc.sck && n < 50);
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!ifc.sck && n < 100);
    check("sck_period", n, 10);
    check("t1_level_after_load", ifc.fifo_level, 1);
    wait_drain("t1_drain", 2000);
    ifc.en = 1'b0;
    @(negedge clk);
    check("t1_level_end", ifc.fifo_level, 0);
    check("t1_empty_end", ifc.fifo_empty, 1);

    // Left only, 24-bit samples, upper garbage must be ignored
    ifc.channels    = 2'b01;
    ifc.sample_size = 5'd24;
    write_word(32'h77A5_F00F);
    write_word(32'h0012_3456);
    write_word(32'hFF80_0001);
    exp_q.push_back('{ws: 1'b0, bits: slot_pat(32'h77A5_F00F, 24)});
    exp_q.push_back('{ws: 1'b1, bits: 32'h0});
    exp_q.push_back('{ws: 1'b0, bits: slot_pat(32'h0012_3456, 24)});
    exp_q.push_back('{ws: 1'b1, bits: 32'h0});
    exp_q.push_back('{ws: 1'b0, bits: slot_pat(32'hFF80_0001, 24)});
    exp_q.push_back('{ws: 1'b1, bits: 32'h0});
    check("t2_level_pre", ifc.fifo_level, 3);
    ifc.en = 1'b1;
    @(negedge clk);
    check("t2_level_after_first", ifc.fifo_level, 2);
    wait_drain("t2_drain", 5000);
    ifc.en = 1'b0;
    @(negedge clk);
    check("t2_level_end", ifc.fifo_level, 0);

    // Empty FIFO, stereo: zero slots and underflow flag behaviour
    ifc.channels    = 2'b11;
    ifc.sample_size = 5'd18;
    exp_q.push_back('{ws: 1'b0, bits: 32'h0});
    exp_q.push_back('{ws: 1'b1, bits: 32'h0});
    ifc.en = 1'b1;
`ifdef I2S_TX_UNDERFLOW_EN
    @(posedge clk);
    #1;
    check("uf_first_load", ifc.underflow, 1);
    @(negedge clk);
    ifc.underflow_clr = 1'b1;
    @(negedge clk);
    ifc.underflow_clr = 1'b0;
    check("uf_cleared", ifc.underflow, 0);
    n = 0;
    while (!ifc.ws && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("uf_right_slot_ws", ifc.ws, 1);
    check("uf_reset_at_right", ifc.underflow, 1);
`endif
    wait_drain("t3_drain", 2000);
    ifc.en = 1'b0;
    @(negedge clk);
    check("t3_level", ifc.fifo_level, 0);

    // Table: fill FIFO with en=0, 17th write dropped
    for (int i = 0; i < 17; i++) begin
      vecs[i].wdata = 32'hFFFC_0000 | ((i * 32'h1357 + 32'h0800) & 32'h0003_FFFF);
      vecs[i].lvl   = (i < 16) ? 5'(i + 1) : 5'd16;
      vecs[i].full  = (i >= 15);
      vecs[i].empty = 1'b0;
      vecs[i].below = (vecs[i].lvl < 5'd5);
    end
    for (int i = 0; i < 17; i++) begin
      write_word(vecs[i].wdata);
      check("tbl_level", ifc.fifo_level, vecs[i].lvl);
      check("tbl_full", ifc.fifo_full, vecs[i].full);
      check("tbl_empty", ifc.fifo_empty, vecs[i].empty);
      check("tbl_below", ifc.fifo_level_below, vecs[i].below);
    end

    // Drain stereo while watching the threshold, then drop en mid right slot
    for (int i = 0; i < 11; i++)
      exp_q.push_back('{ws: 1'(i % 2), bits: slot_pat(vecs[i].wdata, 18)});
    ifc.en = 1'b1;
    wait_level("thr_level5", 5'd5, 8000);
    check("thr_below_at5", ifc.fifo_level_below, 0);
    wait_level("thr_level4", 5'd4, 2000);
    check("thr_below_at4", ifc.fifo_level_below, 1);
    check("t5_slots_done", exp_q.size(), 0);
    base = fall_cnt;
    n = 0;
    while (fall_cnt < base + 10 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("t5_bitcnt10", fall_cnt - base, 10);
    check("t5_ws_right", ifc.ws, 1);
    ifc.en = 1'b0;
    @(posedge clk);
    #1;
    check("t5_sck_off", ifc.sck, 0);
    check("t5_ws_off", ifc.ws, 0);
    check("t5_sdo_off", ifc.sdo, 0);
    w12 = vecs[12].wdata;
    w13 = vecs[13].wdata;
    exp_q.push_back('{ws: 1'b0, bits: slot_pat(w12, 18)});
    exp_q.push_back('{ws: 1'b1, bits: slot_pat(w13, 18)});
    @(negedge clk);
    ifc.en = 1'b1;
    wait_drain("t5_restart_drain", 2000);
    ifc.en = 1'b0;
    @(negedge clk);
    check("t5_level_end", ifc.fifo_level, 2);

    // Asynchronous reset mid-frame with level 7
    mon_on = 1'b0;
    for (int i = 0; i < 6; i++) write_word(32'h0000_1000 + 32'(i));
    ifc.en = 1'b1;
    repeat (120) @(negedge clk);
    check("t6_level_pre", ifc.fifo_level, 7);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_sck", ifc.sck, 0);
    check("t6_ws", ifc.ws, 0);
    check("t6_sdo", ifc.sdo, 0);
    check("t6_level", ifc.fifo_level, 0);
    check("t6_empty", ifc.fifo_empty, 1);
    check("t6_full", ifc.fifo_full, 0);
    check("t6_below", ifc.fifo_level_below, 1);
`ifdef I2S_TX_UNDERFLOW_EN
    check("t6_underflow", ifc.underflow, 0);
`endif
    ifc.en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/i2s_tx.md
# i2s_tx

I2S master transmitter: the playback counterpart to the I2S receiver. Buffers samples written by the bus-side wrapper in an internal FIFO, generates `sck` and `ws` from the system clock, and shifts samples out MSB-first on `sdo` using Philips I2S timing. It sits between the register/APB wrapper and an external DAC or codec.

## Interface
- `FIFO_AW`, 4: FIFO address width; depth = 2^FIFO_AW words of 32 bits.
- `clk` in 1: system clock, all logic on rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `sdo` out 1: serial data to DAC.
- `ws` out 1: word select; 0 = left slot, 1 = right slot.
- `sck` out 1: serial bit clock.
- `fifo_wr` in 1: write strobe, one word per cycle.
- `fifo_wdata` in 32: sample, right-aligned in bits [sample_size-1:0].
- `fifo_level_threshold` in FIFO_AW+1: refill threshold.
- `fifo_full` out 1: level == 2^FIFO_AW.
- `fifo_empty` out 1: level == 0.
- `fifo_level` out FIFO_AW+1: words held.
- `fifo_level_below` out 1: fifo_level < fifo_level_threshold.
- `sample_size` in 5: data bits per slot, 1–31; 0 sends all-zero slots.
- `sck_prescaler` in 8: sck half-period = sck_prescaler+1 clk cycles.
- `channels` in 2: 01 left only, 10 right only, 11 stereo, 00 no data (zeros, no pops).
- `en` in 1: transmitter enable.

## Operation
- Reset: `sck`=0, `ws`=0, `sdo`=0, FIFO empty, `fifo_level`=0, `fifo_empty`=1, `fifo_full`=0, `fifo_level_below`=(threshold>0).
- States: IDLE (en=0) and RUN. IDLE: `sck`,`ws`,`sdo` held 0, prescaler and bit counter cleared; FIFO retains contents and accepts writes.
- IDLE→RUN on first clk with en=1: slot = left, bit_cnt=0, left word loaded (see load rule). RUN→IDLE the cycle after en falls, mid-frame allowed; in-flight word discarded.
- Prescaler counts 0..sck_prescaler; on terminal count `sck` toggles. sck fall = "bit edge"; bit_cnt increments mod 32 on each bit edge; on wrap to 0 `ws` toggles and the next slot's word is loaded.
- Load rule: if slot active per `channels`, pop FIFO head into shift register left-aligned (word << (32-sample_size)), bits outside sample_size zeroed; inactive slot loads 0 without popping. Empty FIFO at load → load 0 (underflow).
- `sdo` per slot: bit_cnt 0 → 0; bit_cnt n in 1..sample_size → sample bit [sample_size-n]; remainder 0. Frame = 64 sck.
- FIFO: write when fifo_wr && !fifo_full; write while full dropped, no state change. Simultaneous write and pop on nonempty FIFO: level unchanged. Write and pop on empty FIFO in same cycle: pop underflows, write stored (level→1).
- Config inputs sampled at each load; changes mid-slot take effect at next slot.

## Timing
- sck rises (p+1) clk after RUN entry, p = sck_prescaler; period 2(p+1) clk.
- `sdo`, `ws` change only in the clk cycle of a bit edge (sck falling), stable across sck rise.
- Pop occurs in the same clk as the bit edge that starts the slot; `fifo_level` updates next cycle.
- `fifo_full`, `fifo_empty`, `fifo_level_below` registered, consistent with `fifo_level`.

## Configuration
- `I2S_TX_UNDERFLOW_EN`: defined → adds output `underflow` (1) and input `underflow_clr` (1); `underflow` set on any load of an active slot from empty FIFO, sticky until `underflow_clr` pulse (set wins if same cycle); reset 0. Undefined → ports absent, underflow silently transmits zeros.

## Test plan
- Reset 1000 ns, p=4, sample_size=18, channels=11, write 0x2ABCD, 0x15432, en=1 → sck period 10 clk; left slot sdo bits 1..18 = 10_1010_1011_1100_1101, right = 01_0101_0100_0011_0010, all other slot bits 0, ws toggles every 32 sck.
- channels=01, write 3 words → one pop per frame, right slots all zero, level 3→0 over 3 frames.
- en=1 with empty FIFO, stereo → sdo constant 0; with macro, underflow=1 at first load, cleared by underflow_clr, re-set at next slot.
- en=0, write 17 words → fifo_full after 16th, 17th dropped, level=16; threshold=5 → fifo_level_below=0 until level drops to 4 while running.
- Deassert en at bit_cnt 10 of right slot → next cycle sck=ws=sdo=0; re-enable → restarts with left slot using next FIFO word.
- Assert rst_n=0 mid-frame with level 7 → all outputs to reset values immediately, level=0.
